fetch_sequencer: RTL and testbench

Front-end controller that owns the program counter and sequences instruction fetch for the pipeline. It issues requests to instruction memory over a req/ack handshake and presents fetched instructions to decode through a registered output slot plus a one-entry skid buffer. It honours decode stalls, and applies taken-branch redirects from execute-stage branch resolution, discarding wrong-path data. It sits between the branch unit's redirect outputs, instruction memory and the IF/ID boundary.

---
 rtl/fetch_sequencer.sv | 153 +++++++++++++++
 tb/tb_fetch_sequencer.sv | 197 +++++++++++++++++++
 2 files changed

// File: rtl/fetch_sequencer.sv
// fetch_sequencer: owns the PC and sequences instruction fetch into the IF/ID slot.
// Fetched instructions land in a registered output slot. A one-entry skid buffer
// catches the single in-flight response that arrives while decode is stalled.
// Taken-branch redirects flush both buffers. When a request is still outstanding
// at the time of a redirect, that request's response is drained before the
// sequencer moves to the new target.
module fetch_sequencer #(
   parameter int              mbus     = 32,
   parameter logic [mbus-1:0] RESET_PC = '0
) (
   input  logic            clk,
   input  logic            rst,
   input  logic            stall,
   input  logic            redirect_valid,
   input  logic [mbus-1:0] redirect_pc,
   output logic            imem_req,
   output logic [mbus-1:0] imem_addr,
   input  logic            imem_ack,
   input  logic [31:0]     imem_rdata,
   output logic            if_valid,
   output logic [mbus-1:0] if_pc,
   output logic [31:0]     if_instr
);

   typedef enum logic [1:0] {IDLE, FETCH, HOLD, DRAIN} state_t;

   state_t          state, state_next;
   logic [mbus-1:0] fetch_addr, fetch_addr_next;
   logic [mbus-1:0] next_pc, next_pc_next;
   logic            skid_valid, skid_valid_next;
   logic [mbus-1:0] skid_pc, skid_pc_next;
   logic [31:0]     skid_instr, skid_instr_next;
   logic            valid_next;
   logic [mbus-1:0] pc_next;
   logic [31:0]     instr_next;
   logic            slot_free;

   assign slot_free = !if_valid || !stall;
   assign imem_addr = fetch_addr;

   // State register; reset drops imem_req immediately because req decodes from state.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) state <= IDLE;
      else     state <= state_next;
   end

   // Next-state, request and buffer-update decisions; redirect is applied last so it overrides everything.
   always_comb begin
      state_next      = state;
      fetch_addr_next = fetch_addr;
      next_pc_next    = next_pc;
      valid_next      = if_valid;
      pc_next         = if_pc;
      instr_next      = if_instr;
      skid_valid_next = skid_valid;
      skid_pc_next    = skid_pc;
      skid_instr_next = skid_instr;
      imem_req        = 1'b0;

      // A slot that decode consumed (or never filled) empties unless refilled below.
      if (slot_free) valid_next = 1'b0;

      case (state)
         IDLE: begin
            state_next = FETCH;
         end
         FETCH: begin
            imem_req = 1'b1;
            if (imem_ack) begin
               fetch_addr_next = fetch_addr + mbus'(4);
               if (slot_free) begin
                  valid_next = 1'b1;
                  pc_next    = fetch_addr;
                  instr_next = imem_rdata;
               end else begin
                  skid_valid_next = 1'b1;
                  skid_pc_next    = fetch_addr;
                  skid_instr_next = imem_rdata;
                  state_next      = HOLD;
               end
            end
         end
         HOLD: begin
            if (!stall) begin
               valid_next      = 1'b1;
               pc_next         = skid_pc;
               instr_next      = skid_instr;
               skid_valid_next = 1'b0;
               state_next      = FETCH;
            end
         end
         DRAIN: begin
            // The wrong-path response is swallowed; only its completion matters.
            imem_req = 1'b1;
            if (imem_ack) begin
               fetch_addr_next = next_pc;
               state_next      = FETCH;
            end
         end
      endcase

      if (redirect_valid) begin
         valid_next      = 1'b0;
         skid_valid_next = 1'b0;
         case (state)
            FETCH: begin
               if (imem_ack) begin
                  fetch_addr_next = redirect_pc;
                  state_next      = FETCH;
               end else begin
                  next_pc_next = redirect_pc;
                  state_next   = DRAIN;
               end
            end
            DRAIN: begin
               next_pc_next = redirect_pc;
               if (imem_ack) begin
                  fetch_addr_next = redirect_pc;
                  state_next      = FETCH;
               end
            end
            default: begin
               fetch_addr_next = redirect_pc;
               state_next      = FETCH;
            end
         endcase
      end
   end

   // Address, skid and output-slot registers.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         fetch_addr <= RESET_PC;
         next_pc    <= RESET_PC;
         skid_valid <= 1'b0;
         skid_pc    <= '0;
         skid_instr <= '0;
         if_valid   <= 1'b0;
         if_pc      <= '0;
         if_instr   <= '0;
      end else begin
         fetch_addr <= fetch_addr_next;
         next_pc    <= next_pc_next;
         skid_valid <= skid_valid_next;
         skid_pc    <= skid_pc_next;
         skid_instr <= skid_instr_next;
         if_valid   <= valid_next;
         if_pc      <= pc_next;
         if_instr   <= instr_next;
      end
   end

endmodule

// File: tb/tb_fetch_sequencer.sv
// Testbench for fetch_sequencer: randomized stall/ack/redirect traffic checked
// every cycle against a transaction-level reference model. The model treats the
// output slot plus skid as a two-deep queue of {pc, instr} entries. It tracks
// whether an outstanding response belongs to the wrong path and must be discarded.
module tb_fetch_sequencer;

   logic        clk = 1'b0;
   logic        rst;
   logic        stall;
   logic        redirect_valid;
   logic [31:0] redirect_pc;
   logic        imem_req;
   logic [31:0] imem_addr;
   logic        imem_ack;
   logic [31:0] imem_rdata;
   logic        if_valid;
   logic [31:0] if_pc;
   logic [31:0] if_instr;

   int n_checks = 0;
   int n_errors = 0;

   fetch_sequencer #(.mbus(32), .RESET_PC(32'h0)) dut (
      .clk           (clk),
      .rst           (rst),
      .stall         (stall),
      .redirect_valid(redirect_valid),
      .redirect_pc   (redirect_pc),
      .imem_req      (imem_req),
      .imem_addr     (imem_addr),
      .imem_ack      (imem_ack),
      .imem_rdata    (imem_rdata),
      .if_valid      (if_valid),
      .if_pc         (if_pc),
      .if_instr      (if_instr)
   );

   always #5 clk = ~clk;

   // ---------------- reference model ----------------
   typedef struct packed {
      logic [31:0] pc;
      logic [31:0] ins;
   } ent_t;

   ent_t        q[$];        // front = output slot, second = skid
   logic        m_started;   // first edge after reset has passed
   logic        m_discard;   // outstanding response is wrong-path
   logic [31:0] m_addr;      // address of the next (or outstanding) request
   logic [31:0] m_target;    // where to go once the wrong-path response completes

   task automatic model_reset();
      q.delete();
      m_started = 1'b0;
      m_discard = 1'b0;
      m_addr    = 32'h0;
      m_target  = 32'h0;
   endtask

   // A request is outstanding whenever running and there is room to land its data
   // (or it is a wrong-path request that will be thrown away).
   function automatic logic exp_req();
      return m_started && (m_discard || q.size() < 2);
   endfunction

   // Advance the model across one rising edge using the currently driven inputs.
   task automatic model_step();
      logic r;
      r = exp_req();
      if (redirect_valid) begin
         q.delete();
         if (r) begin
            if (imem_ack) begin
               m_addr    = redirect_pc;
               m_discard = 1'b0;
            end else begin
               m_discard = 1'b1;
               m_target  = redirect_pc;
            end
         end else begin
            m_addr    = redirect_pc;
            m_started = 1'b1;
         end
      end else if (!m_started) begin
         m_started = 1'b1;
      end else begin
         if (q.size() != 0 && !stall) void'(q.pop_front());
         if (r && imem_ack) begin
            if (m_discard) begin
               m_addr    = m_target;
               m_discard = 1'b0;
            end else begin
               q.push_back('{pc: m_addr, ins: imem_rdata});
               m_addr = m_addr + 32'd4;
            end
         end
      end
   endtask

   // ---------------- checking ----------------
   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_checks++;
      if (obs !== exp) begin
         n_errors++;
         $display("FAIL %s: got 0x%08h expected 0x%08h at %0t", tag, obs, exp, $time);
      end
   endtask

   task automatic compare_outputs();
      chk("imem_req", {31'b0, imem_req}, {31'b0, exp_req()});
      chk("imem_addr", imem_addr, m_addr);
      chk("if_valid", {31'b0, if_valid}, {31'b0, q.size() != 0});
      if (q.size() != 0) begin
         chk("if_pc", if_pc, q[0].pc);
         chk("if_instr", if_instr, q[0].ins);
      end
   endtask

   function automatic logic [31:0] pick_target();
      case ($urandom_range(0, 3))
         0:       return 32'hFFFF_FFF8;
         1:       return 32'hFFFF_FFFC;
         default: return {$urandom_range(0, 32'h0000_FFFF), 2'b00};
      endcase
   endfunction

   // One clock: compare at the falling edge, drive new inputs, advance the model.
   task automatic cycle(input int ack_pct, input int stall_pct, input int redir_pct);
      compare_outputs();
      stall          = ($urandom_range(0, 99) < stall_pct);
      redirect_valid = ($urandom_range(0, 99) < redir_pct);
      redirect_pc    = pick_target();
      imem_ack       = exp_req() && ($urandom_range(0, 99) < ack_pct);
      imem_rdata     = $urandom;
      model_step();
      @(negedge clk);
   endtask

   task automatic check_reset_values(input string pfx);
      chk({pfx, "_req"},    {31'b0, imem_req}, 32'd0);
      chk({pfx, "_addr"},   imem_addr, 32'h0);
      chk({pfx, "_valid"},  {31'b0, if_valid}, 32'd0);
      chk({pfx, "_pc"},     if_pc, 32'h0);
      chk({pfx, "_instr"},  if_instr, 32'h0);
   endtask

   // Reset asserted while a request is waiting for its ack.
   task automatic reset_mid_wait();
      int guard;
      guard = 0;
      while (!exp_req() && guard < 20) begin
         cycle(0, 0, 0);
         guard++;
      end
      chk("reach_req", {31'b0, exp_req()}, 32'd1);
      compare_outputs();
      stall = 1'b0; redirect_valid = 1'b0; imem_ack = 1'b0;
      #2 rst = 1'b1;
      #1 check_reset_values("async_rst");
      @(negedge clk);
      check_reset_values("held_rst");
      rst = 1'b0;
      model_reset();
   endtask

   initial begin
      rst = 1'b1; stall = 1'b0; redirect_valid = 1'b0; redirect_pc = 32'h0;
      imem_ack = 1'b0; imem_rdata = 32'h0;
      model_reset();
      repeat (2) @(negedge clk);
      check_reset_values("reset");
      rst = 1'b0;

      // Zero-wait memory, no stalls: one instruction per cycle.
      repeat (40)  cycle(100, 0, 0);
      // Zero-wait with stalls to exercise skid/HOLD.
      repeat (200) cycle(100, 50, 0);
      // Slow memory, stalls, redirects.
      repeat (400) cycle(35, 30, 8);
      reset_mid_wait();
      // Fast memory, heavy stalls, frequent redirects near the address top.
      repeat (400) cycle(80, 60, 12);
      reset_mid_wait();
      repeat (400) cycle(50, 40, 20);

      $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
      $finish;
   end

   // Global watchdog so the bench always terminates.
   initial begin
      #200000;
      $display("FAIL watchdog: got timeout expected completion");
      $fatal(1, "timeout");
   end

endmodule
